multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Main control FSM of the multi-cycle RV32I core. Sequences fetch/decode/execute/memory/writeback over shared ALU, memory and IR.
//  Drives imm_src_o to the immediate generator and all datapath selects and strobes. One instruction in flight.
// PARAMETERS
//  (none; encodings fixed in ctrl_pkg)
// PORTS
//  clk_i         in   1  clock
//  rst_i         in   1  synchronous, active-high reset
//  opcode_i      in   7  IR[6:0], stable from DECODE onward
//  funct3_i      in   3  IR[14:12]
//  zero_i        in   1  ALU zero flag
//  mem_ready_i   in   1  memory ack (used only with MULTICYCLE_MEM_WAIT_EN)
//  imm_src_o     out  3  000 I, 001 S, 010 B, 011 J, 100 U
//  adr_src_o     out  1  0 PC, 1 ALUOut
//  ir_write_o    out  1  latch IR/oldPC
//  pc_write_o    out  1  PC load
//  mem_write_o   out  1  store strobe
//  reg_write_o   out  1  regfile write
//  alu_src_a_o   out  2  00 PC, 01 oldPC, 10 rs1 reg, 11 zero
//  alu_src_b_o   out  2  00 rs2 reg, 01 imm, 10 const 4
//  alu_op_o      out  2  00 add, 01 sub, 10 funct-decoded
//  result_src_o  out  2  00 ALUOut, 01 read data, 10 ALU result
//  retire_o      out  1  1-cycle pulse in final state of each instruction
//  illegal_o     out  1  high while in ILLEGAL
// BEHAVIOUR
//  Reset: state=FETCH on first cycle after rst_i; outputs follow FETCH decode, except pc_write_o/ir_write_o forced 0 while rst_i high.
//  Registered state; outputs Moore (state) except imm_src_o (opcode), pc_write_o in BRANCH (zero_i/funct3_i).
//  Unlisted outputs 0 per state; imm_src_o from opcode_i in every state (lw/jalr/OP-IMM I, sw S, branch B, jal J, lui/auipc U, else 000).
//  FETCH: adr 0, ir_write, a=00 b=10 add, result 10, pc_write -> DECODE.
//  DECODE: a=01 b=01 add (branch/jal/auipc target into ALUOut). Next: lw/sw MEMADR; OP EXECR; OP-IMM EXECI; jal JAL;
//   branch w/ funct3 000/001 BRANCH; jalr JALR_LINK; lui LUI; auipc ALUWB; anything else ILLEGAL.
//  MEMADR: a=10 b=01 add -> MEMRD (lw) / MEMWR (sw).  MEMRD: adr 1 -> MEMWB.  MEMWB: result 01, reg_write, retire -> FETCH.
//  MEMWR: adr 1, mem_write, retire -> FETCH.
//  EXECR: a=10 b=00 op 10 -> ALUWB.  EXECI: a=10 b=01 op 10 -> ALUWB.  LUI: a=11 b=01 add -> ALUWB.
//  ALUWB: result 00, reg_write, retire -> FETCH.
//  JAL: a=01 b=10 add, result 00, pc_write -> ALUWB (writes oldPC+4).
//  JALR_LINK: a=01 b=10 add, result 10, reg_write -> JALR.  JALR: a=10 b=01 add, result 10, pc_write, retire -> FETCH.
//  BRANCH: a=10 b=00 sub, result 00, pc_write = (f3==000 & zero_i)|(f3==001 & ~zero_i), retire -> FETCH.
//  ILLEGAL: all strobes 0, illegal_o=1, absorbing until rst_i.
//  Cycles: branch/auipc 3; R/I/lui/jal/jalr/sw 4; lw 5 (no wait states).
//  rst_i mid-instruction: abandon, no strobe that cycle, FETCH next.
// CONFIGURATION
//  MULTICYCLE_MEM_WAIT_EN defined: FETCH, MEMRD, MEMWR hold while mem_ready_i=0; ir_write_o, pc_write_o, mem_write_o (and state advance)
//   asserted only in the cycle mem_ready_i=1; adr/alu selects held stable during wait.
//  Undefined: mem_ready_i ignored, memory states single-cycle.
// STRUCTURE
//  ctrl_pkg: state_t enum, opcode constants (LOAD 0000011, STORE 0100011, OP 0110011, OP_IMM 0010011, BRANCH 1100011,
//   JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111), imm_src/alu_src/result_src/alu_op enums.
//  Sub-module imm_src_decoder: combinational opcode -> imm_src_o; FSM is state reg + next-state + output decode.
// TESTING
//  Reset 3 cycles then release -> FETCH: pc_write=ir_write=1, a=00 b=10, retire=0, illegal=0.
//  add (0x33), then lw (0x03) -> states F,D,EXECR,ALUWB (retire cyc4), then F,D,MEMADR,MEMRD,MEMWB (result 01, reg_write cyc5).
//  beq f3=000 zero_i=1 -> pc_write in BRANCH; zero_i=0 -> no pc_write; bne f3=001 inverse; f3=100 -> ILLEGAL.
//  jalr: JALR_LINK reg_write result 10, then JALR pc_write; imm_src=000 throughout; lui imm_src=100, a=11.
//  opcode 0x7F -> ILLEGAL, illegal_o held 20 cycles, no strobes; rst_i pulse -> FETCH.
//  MEM_WAIT_EN: mem_ready_i low 3 cycles in MEMWR -> state held, mem_write=0, then 1 cycle mem_write=1, retire.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// multicycle_ctrl_fsm_pkg: shared encodings for the multi-cycle RV32I control FSM.
package multicycle_ctrl_fsm_pkg;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
      S_LUI, S_ALUWB, S_JAL, S_JALR_LINK, S_JALR, S_BRANCH, S_ILLEGAL
   } state_t;
   typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100} imm_src_t;
   typedef enum logic [1:0] {A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10, A_ZERO = 2'b11} alu_src_a_t;
   typedef enum logic [1:0] {B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10} alu_src_b_t;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_FUNCT = 2'b10} alu_op_t;
   typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_RDATA = 2'b01, RES_ALU = 2'b10} result_src_t;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
endpackage

// File: rtl/multicycle_ctrl_fsm_imm_dec.sv
// multicycle_ctrl_fsm_imm_dec: opcode to immediate-format select.
module multicycle_ctrl_fsm_imm_dec
   import multicycle_ctrl_fsm_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic [2:0] imm_src_o
);
   imm_src_t imm;
   always_comb begin
      imm = (opcode_i == OPC_STORE) ? IMM_S :
            (opcode_i == OPC_BRANCH) ? IMM_B :
            (opcode_i == OPC_JAL) ? IMM_J :
            (opcode_i == OPC_LUI || opcode_i == OPC_AUIPC) ? IMM_U : IMM_I;
   end
   assign imm_src_o = imm;
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: main control FSM of the multi-cycle RV32I core.
// Define MULTICYCLE_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready_i.
module multicycle_ctrl_fsm
   import multicycle_ctrl_fsm_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic [2:0] imm_src_o,
   output logic       adr_src_o,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic       mem_write_o,
   output logic       reg_write_o,
   output logic [1:0] alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] alu_op_o,
   output logic [1:0] result_src_o,
   output logic       retire_o,
   output logic       illegal_o
);
   state_t      state_q, state_d;
   alu_src_a_t  a;
   alu_src_b_t  b;
   alu_op_t     op;
   result_src_t res;
   logic rdy, adr, irw, pcw, mw, rw, ret, ill, take;
`ifdef MULTICYCLE_MEM_WAIT_EN
   assign rdy = mem_ready_i;
`else
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready_i;
   assign rdy = 1'b1;
`endif
   assign take = (funct3_i == 3'b000 && zero_i) || (funct3_i == 3'b001 && !zero_i);
   multicycle_ctrl_fsm_imm_dec u_imm_dec (.opcode_i(opcode_i), .imm_src_o(imm_src_o));
   always_comb begin
      state_d = state_q;
      adr = 1'b0;
      irw = 1'b0;
      pcw = 1'b0;
      mw  = 1'b0;
      rw  = 1'b0;
      ret = 1'b0;
      ill = 1'b0;
      a   = A_PC;
      b   = B_RS2;
      op  = OP_ADD;
      res = RES_ALUOUT;
      case (state_q)
         S_FETCH: begin
            irw = rdy;
            pcw = rdy;
            b = B_FOUR;
            res = RES_ALU;
            state_d = rdy ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            a = A_OLDPC;
            b = B_IMM;
            state_d = (opcode_i == OPC_LOAD || opcode_i == OPC_STORE) ? S_MEMADR :
                      (opcode_i == OPC_OP) ? S_EXECR :
                      (opcode_i == OPC_OP_IMM) ? S_EXECI :
                      (opcode_i == OPC_JAL) ? S_JAL :
                      (opcode_i == OPC_BRANCH && funct3_i[2:1] == 2'b00) ? S_BRANCH :
                      (opcode_i == OPC_JALR) ? S_JALR_LINK :
                      (opcode_i == OPC_LUI) ? S_LUI :
                      (opcode_i == OPC_AUIPC) ? S_ALUWB : S_ILLEGAL;
         end
         S_MEMADR: begin
            a = A_RS1;
            b = B_IMM;
            state_d = (opcode_i == OPC_LOAD) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            adr = 1'b1;
            state_d = rdy ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            res = RES_RDATA;
            rw = 1'b1;
            ret = 1'b1;
            state_d = S_FETCH;
         end
         S_MEMWR: begin
            adr = 1'b1;
            mw = rdy;
            ret = rdy;
            state_d = rdy ? S_FETCH : S_MEMWR;
         end
         S_EXECR: begin
            a = A_RS1;
            op = OP_FUNCT;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            a = A_RS1;
            b = B_IMM;
            op = OP_FUNCT;
            state_d = S_ALUWB;
         end
         S_LUI: begin
            a = A_ZERO;
            b = B_IMM;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            rw = 1'b1;
            ret = 1'b1;
            state_d = S_FETCH;
         end
         S_JAL: begin
            a = A_OLDPC;
            b = B_FOUR;
            pcw = 1'b1;
            state_d = S_ALUWB;
         end
         S_JALR_LINK: begin
            a = A_OLDPC;
            b = B_FOUR;
            res = RES_ALU;
            rw = 1'b1;
            state_d = S_JALR;
         end
         S_JALR: begin
            a = A_RS1;
            b = B_IMM;
            res = RES_ALU;
            pcw = 1'b1;
            ret = 1'b1;
            state_d = S_FETCH;
         end
         S_BRANCH: begin
            a = A_RS1;
            op = OP_SUB;
            pcw = take;
            ret = 1'b1;
            state_d = S_FETCH;
         end
         S_ILLEGAL: ill = 1'b1;
         default: state_d = S_FETCH;
      endcase
   end
   always_ff @(posedge clk_i) state_q <= rst_i ? S_FETCH : state_d;
   // Strobes are suppressed while reset is held so an abandoned instruction has no side effects.
   assign ir_write_o   = irw & ~rst_i;
   assign pc_write_o   = pcw & ~rst_i;
   assign mem_write_o  = mw & ~rst_i;
   assign reg_write_o  = rw & ~rst_i;
   assign retire_o     = ret & ~rst_i;
   assign adr_src_o    = adr;
   assign alu_src_a_o  = a;
   assign alu_src_b_o  = b;
   assign alu_op_o     = op;
   assign result_src_o = res;
   assign illegal_o    = ill;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed per-cycle checks of every control output against hand-built state rows.
module tb_multicycle_ctrl_fsm;
   localparam int F = 0, D = 1, XR = 2, XI = 3, AW = 4, MA = 5, MR = 6, MW = 7;
   localparam int SW = 8, LU = 9, JA = 10, JL = 11, JR = 12, BR = 13, IL = 14;
   localparam logic [17:0] STROBES = 18'h03C02;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic [6:0] opcode_i = 7'h33;
   logic [2:0] funct3_i = 3'b000;
   logic zero_i = 1'b0;
   logic mem_ready_i = 1'b1;
   logic [2:0] imm_src_o;
   logic adr_src_o, ir_write_o, pc_write_o, mem_write_o, reg_write_o, retire_o, illegal_o;
   logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
   logic [17:0] obs, exp;
   int checks = 0;
   int fails = 0;
   always #5 clk_i = ~clk_i;
   multicycle_ctrl_fsm dut (
      .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .zero_i(zero_i),
      .mem_ready_i(mem_ready_i), .imm_src_o(imm_src_o), .adr_src_o(adr_src_o), .ir_write_o(ir_write_o),
      .pc_write_o(pc_write_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
      .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
      .result_src_o(result_src_o), .retire_o(retire_o), .illegal_o(illegal_o)
   );
   assign obs = {imm_src_o, adr_src_o, ir_write_o, pc_write_o, mem_write_o, reg_write_o,
                 alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, retire_o, illegal_o};
   // Row layout: adr irw pcw mw rw | a | b | op | res | ret ill
   function automatic logic [17:0] exp_vec(int s, logic [2:0] imm, logic take);
      logic [14:0] r;
      case (s)
         F:  r = {5'b01100, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
         D:  r = {5'b00000, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
         XR: r = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
         XI: r = {5'b00000, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
         AW: r = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
         MA: r = {5'b00000, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
         MR: r = {5'b10000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
         MW: r = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
         SW: r = {5'b10010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
         LU: r = {5'b00000, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00};
         JA: r = {5'b00100, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
         JL: r = {5'b00001, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00};
         JR: r = {5'b00100, 2'b10, 2'b01, 2'b00, 2'b10, 2'b10};
         BR: r = {2'b00, take, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
         IL: r = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
         default: r = '0;
      endcase
      return {imm, r};
   endfunction
   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      #1;
      exp = exp_vec(F, 3'b000, 1'b0) & ~STROBES;
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL reset: got %h want %h", obs, exp);
      end
      @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask
   task automatic test_add_lw();
      int s[9];
      s = '{F, D, XR, AW, F, D, MA, MR, MW};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk_i);
         opcode_i = (i < 4) ? 7'h33 : 7'h03;
         #1;
         exp = exp_vec(s[i], 3'b000, 1'b0);
         checks++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL add_lw cyc%0d: got %h want %h", i, obs, exp);
         end
      end
   endtask
   task automatic test_branch();
      logic [2:0] f3s[5];
      logic zs[5];
      logic tk[5];
      f3s = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
      zs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tk = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            opcode_i = 7'h63;
            funct3_i = f3s[k];
            zero_i = zs[k];
            #1;
            exp = exp_vec(c == 0 ? F : c == 1 ? D : (k == 4 ? IL : BR), 3'b010, tk[k]);
            checks++;
            if (obs !== exp) begin
               fails++;
               $display("FAIL branch k%0d cyc%0d: got %h want %h", k, c, obs, exp);
            end
         end
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      exp = exp_vec(IL, 3'b010, 1'b0);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL branch_rst: got %h want %h", obs, exp);
      end
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      funct3_i = 3'b000;
   endtask
   task automatic test_jump_upper();
      logic [6:0] ops[15];
      logic [2:0] imms[15];
      int s[15];
      ops  = '{7'h67, 7'h67, 7'h67, 7'h67, 7'h37, 7'h37, 7'h37, 7'h37,
               7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h17, 7'h17, 7'h17};
      imms = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b100, 3'b100,
               3'b011, 3'b011, 3'b011, 3'b011, 3'b100, 3'b100, 3'b100};
      s    = '{F, D, JL, JR, F, D, LU, AW, F, D, JA, AW, F, D, AW};
      for (int i = 0; i < 15; i++) begin
         @(negedge clk_i);
         opcode_i = ops[i];
         #1;
         exp = exp_vec(s[i], imms[i], 1'b0);
         checks++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL jump_upper cyc%0d: got %h want %h", i, obs, exp);
         end
      end
   endtask
   task automatic test_store_opimm();
      logic [2:0] imms[8];
      int s[8];
      imms = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
      s = '{F, D, MA, SW, F, D, XI, AW};
`ifndef MULTICYCLE_MEM_WAIT_EN
      mem_ready_i = 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         opcode_i = (i < 4) ? 7'h23 : 7'h13;
         #1;
         exp = exp_vec(s[i], imms[i], 1'b0);
         checks++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL store_opimm cyc%0d: got %h want %h", i, obs, exp);
         end
      end
      mem_ready_i = 1'b1;
   endtask
   task automatic test_illegal();
      for (int i = 0; i < 22; i++) begin
         @(negedge clk_i);
         opcode_i = 7'h7F;
         zero_i = i[0];
         funct3_i = 3'(i);
         #1;
         exp = exp_vec(i == 0 ? F : i == 1 ? D : IL, 3'b000, 1'b0);
         checks++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL illegal cyc%0d: got %h want %h", i, obs, exp);
         end
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      exp = exp_vec(IL, 3'b000, 1'b0);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL illegal_rst: got %h want %h", obs, exp);
      end
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      funct3_i = 3'b000;
      zero_i = 1'b0;
   endtask
`ifdef MULTICYCLE_MEM_WAIT_EN
   task automatic test_mem_wait();
      int s[8];
      logic rdys[8];
      s = '{F, D, MA, SW, SW, SW, SW, F};
      rdys = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_i);
         opcode_i = 7'h23;
         mem_ready_i = rdys[i];
         #1;
         exp = exp_vec(s[i], 3'b001, 1'b0) & (rdys[i] ? 18'h3FFFF : ~STROBES);
         checks++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL mem_wait cyc%0d: got %h want %h", i, obs, exp);
         end
      end
      mem_ready_i = 1'b1;
   endtask
`endif
   task automatic test_mid_reset();
      int s[4];
      s = '{F, D, MA, MR};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         opcode_i = 7'h03;
         rst_i = (i == 4);
         #1;
         exp = (i < 4) ? exp_vec(s[i], 3'b000, 1'b0) :
               (i == 4) ? exp_vec(MW, 3'b000, 1'b0) & ~STROBES : exp_vec(F, 3'b000, 1'b0);
         checks++;
         if (obs !== exp) begin
            fails++;
            $display("FAIL mid_reset cyc%0d: got %h want %h", i, obs, exp);
         end
      end
   endtask
   initial begin
      test_reset();
      test_add_lw();
      test_branch();
      test_jump_upper();
      test_store_opimm();
      test_illegal();
`ifdef MULTICYCLE_MEM_WAIT_EN
      test_mem_wait();
`endif
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
